// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter that lets NUM_MASTERS requesters share one memory
//   port. One transaction is in flight at a time. A grant is registered on
//   the edge after a request is seen in IDLE. The granted master's attributes
//   are then steered combinationally onto the memory side until s_ready
//   completes the access.
//
// Optional feature (compile-time macro):
//   MEM_ARB_LOCK_EN - adds m_lock. A completion with the granted master's
//                     m_lock high keeps the arbiter locked to that master, so
//                     it can run atomic sequences. A completion with m_lock
//                     low releases the lock.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   m_req   [N]        per-master request (level)
//   m_we    [N]        per-master write enable
//   m_addr  [N*AW]     packed addresses, master i at [i*AW +: AW]
//   m_wdata [N*DW]     packed write data, master i at [i*DW +: DW]
//   m_lock  [N]        (MEM_ARB_LOCK_EN only) lock request per master
//   m_ready [N]        one-cycle completion pulse to the granted master
//   m_rdata [DW]       read data, a pass-through of s_rdata
//   s_req/s_we/s_addr/s_wdata  memory-side access, zero when idle
//   s_ready, s_rdata   memory completion pulse and read data
//   gnt_id             index of the current or last granted master
//   busy               high while a transaction is outstanding
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = 32,
  parameter  int unsigned DATA_W      = 32,
  localparam int unsigned GW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]        m_lock,
`endif
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [GW-1:0]                 gnt_id,
  output logic                          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_gnt_id;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     w_winner;
  logic [GW-1:0]     w_rr_nxt;
  logic              w_any_req;
  logic              w_grant;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic              r_locked;
  logic              w_sel_lock;
  logic              w_sel_req;
`endif

  // Attributes of the master addressed by r_gnt_id. Constant-index
  // compares keep this free of out-of-range selects for any NUM_MASTERS.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    w_sel_lock  = 1'b0;
    w_sel_req   = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (r_gnt_id == GW'(i)) begin
        w_sel_we    = m_we[i];
        w_sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
`ifdef MEM_ARB_LOCK_EN
        w_sel_lock  = m_lock[i];
        w_sel_req   = m_req[i];
`endif
      end
    end
  end

  // Round-robin scan. Priority slot k maps to master (rr_ptr + k) mod N.
  // The first requesting slot wins.
  always_comb begin : rr_arb
    int unsigned t;
    logic        found;
    found    = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      t = k + 32'(r_rr_ptr);
      if (t >= NUM_MASTERS) t = t - NUM_MASTERS;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!found && (t == i) && m_req[i]) begin
          found    = 1'b1;
          w_winner = GW'(i);
        end
      end
    end
    w_any_req = found;
`ifdef MEM_ARB_LOCK_EN
    // While locked, only the lock owner may be granted.
    if (r_locked) begin
      w_any_req = w_sel_req;
      w_winner  = r_gnt_id;
    end
`endif
  end

  always_comb begin
    w_rr_nxt = w_winner + GW'(1);
    if (32'(w_winner) == NUM_MASTERS - 1) w_rr_nxt = '0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = BUSY;
          w_grant     = 1'b1;
        end
      end
      BUSY: begin
        if (s_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    m_ready = '0;
    busy    = 1'b0;
    m_rdata = s_rdata;
    gnt_id  = r_gnt_id;
    if (r_state == BUSY) begin
      busy    = 1'b1;
      s_req   = 1'b1;
      s_we    = w_sel_we;
      s_addr  = w_sel_addr;
      s_wdata = w_sel_wdata;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        m_ready[i] = s_ready && (r_gnt_id == GW'(i));
      end
    end
  end

  // Grant index and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_id <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_gnt_id <= w_winner;
`ifdef MEM_ARB_LOCK_EN
      if (!r_locked) r_rr_ptr <= w_rr_nxt;
`else
      r_rr_ptr <= w_rr_nxt;
`endif
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Every completion re-samples the owner's lock request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_locked <= 1'b0;
    else if ((r_state == BUSY) && s_ready) r_locked <= w_sel_lock;
  end
`endif

endmodule
